// File: rtl/risc16_alu.sv
// risc16_alu: registered RiSC-16 ALU with result word and zero flag.
// Optional shifter on codes 6/7 enabled by defining RISC16_ALU_SHIFT_EN.

`ifndef ALU_FUNCT_LEN
`define ALU_FUNCT_LEN 3
`endif
`ifndef ALU_ADD
`define ALU_ADD   3'b000
`define ALU_SUB   3'b001
`define ALU_NAND  3'b010
`define ALU_PASS1 3'b011
`define ALU_PASS2 3'b100
`define ALU_EQ    3'b101
`define ALU_SHL   3'b110
`define ALU_SHR   3'b111
`endif

module risc16_alu #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_LENGTH-1:0]    src1,
    input  logic [WORD_LENGTH-1:0]    src2,
    input  logic [`ALU_FUNCT_LEN-1:0] funct,
    output logic [WORD_LENGTH-1:0]    result,
    output logic                      state
);

    localparam int SHW = $clog2(WORD_LENGTH);

    logic [WORD_LENGTH-1:0] w_result;
    logic                   w_zero;
    logic [WORD_LENGTH-1:0] r_result;
    logic                   r_state;

`ifdef RISC16_ALU_SHIFT_EN
    logic [SHW-1:0] w_shamt;
    assign w_shamt = src2[SHW-1:0];
`endif

    // Select the operation result; unused codes yield zero.
    always_comb begin
        w_result = '0;
        case (funct)
            `ALU_ADD:   w_result = src1 + src2;
            `ALU_SUB:   w_result = src1 - src2;
            `ALU_NAND:  w_result = ~(src1 & src2);
            `ALU_PASS1: w_result = src1;
            `ALU_PASS2: w_result = src2;
            `ALU_EQ:    w_result = {{(WORD_LENGTH-1){1'b0}}, (src1 == src2)};
`ifdef RISC16_ALU_SHIFT_EN
            `ALU_SHL:   w_result = src1 << w_shamt;
            `ALU_SHR:   w_result = src1 >> w_shamt;
`endif
            default:    w_result = '0;
        endcase
    end

    // Zero flag is derived from the value being loaded, so it never lags.
    assign w_zero = (w_result == '0);

    // Register result and flag; reset clears both, overriding any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_state  <= 1'b0;
        end else begin
            r_result <= w_result;
            r_state  <= w_zero;
        end
    end

    assign result = r_result;
    assign state  = r_state;

endmodule

// File: tb/tb_risc16_alu.sv
// tb_risc16_alu: scoreboard bench for risc16_alu.
// Shift expectations follow RISC16_ALU_SHIFT_EN.

module tb_risc16_alu;

    localparam logic [2:0] F_ADD   = 3'b000;
    localparam logic [2:0] F_SUB   = 3'b001;
    localparam logic [2:0] F_NAND  = 3'b010;
    localparam logic [2:0] F_PASS1 = 3'b011;
    localparam logic [2:0] F_PASS2 = 3'b100;
    localparam logic [2:0] F_EQ    = 3'b101;
    localparam logic [2:0] F_SHL   = 3'b110;
    localparam logic [2:0] F_SHR   = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] src1 = '0;
    logic [15:0] src2 = '0;
    logic [2:0]  funct = '0;
    logic [15:0] result;
    logic        state;

    typedef struct {
        logic [15:0] r;
        logic        s;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    risc16_alu #(.WORD_LENGTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .src1   (src1),
        .src2   (src2),
        .funct  (funct),
        .result (result),
        .state  (state)
    );

    always #5 clk = ~clk;

    // Independent reference for randomized steps.
    function automatic logic [15:0] model(input logic [2:0] f,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] m;
        m = 16'h0000;
        case (f)
            F_ADD:   m = 16'(a + b);
            F_SUB:   m = 16'(a - b);
            F_NAND:  m = ~(a & b);
            F_PASS1: m = a;
            F_PASS2: m = b;
            F_EQ:    m = (a == b) ? 16'h0001 : 16'h0000;
`ifdef RISC16_ALU_SHIFT_EN
            F_SHL:   m = a << b[3:0];
            F_SHR:   m = a >> b[3:0];
`endif
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_asrt++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            n_asrt++;
            assert (result === e.r) else begin
                n_fail++;
                $error("FAIL %s.result observed=%h expected=%h", e.tag, result, e.r);
            end
            n_asrt++;
            assert (state === e.s) else begin
                n_fail++;
                $error("FAIL %s.state observed=%b expected=%b", e.tag, state, e.s);
            end
        end
    endtask

    // Drive one operation, push its expectation, check after the edge.
    task automatic step(input logic r, input logic [2:0] f,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic es,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst   = r;
        funct = f;
        src1  = a;
        src2  = b;
        e.r = er;
        e.s = es;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  f;
        logic [15:0] m;

        step(1'b1, F_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, "reset");
        step(1'b0, F_ADD, 16'h1111, 16'heaaa, 16'hfbbb, 1'b0, "add");
        step(1'b0, F_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "add_wrap");
        step(1'b0, F_SUB, 16'h2222, 16'h2222, 16'h0000, 1'b1, "sub_zero");
        step(1'b0, F_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, "sub_borrow");
        step(1'b0, F_NAND, 16'hFF00, 16'h0FF0, 16'hF0FF, 1'b0, "nand");
        step(1'b0, F_PASS1, 16'h1234, 16'h9999, 16'h1234, 1'b0, "pass1");
        step(1'b0, F_PASS2, 16'h7777, 16'h0000, 16'h0000, 1'b1, "pass2");
        step(1'b0, F_EQ, 16'h5555, 16'h5555, 16'h0001, 1'b0, "eq_same");
        step(1'b0, F_EQ, 16'h5555, 16'h5554, 16'h0000, 1'b1, "eq_diff");
`ifdef RISC16_ALU_SHIFT_EN
        step(1'b0, F_SHL, 16'h0001, 16'h0013, 16'h0008, 1'b0, "shl");
        step(1'b0, F_SHR, 16'h8000, 16'h0004, 16'h0800, 1'b0, "shr");
`else
        step(1'b0, F_SHL, 16'h0001, 16'h0013, 16'h0000, 1'b1, "shl_off");
        step(1'b0, F_SHR, 16'h8000, 16'h0004, 16'h0000, 1'b1, "shr_off");
`endif
        step(1'b0, F_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, "b2b_add");
        step(1'b0, F_SUB, 16'h0010, 16'h0001, 16'h000F, 1'b0, "b2b_sub");
        step(1'b1, F_NAND, 16'hFF00, 16'h0FF0, 16'h0000, 1'b0, "b2b_rst");
        step(1'b0, F_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, "nand_zero");

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = (i % 4 == 0) ? a : 16'($urandom);
            f = 3'($urandom_range(0, 7));
            m = model(f, a, b);
            step(1'b0, f, a, b, m, (m == 16'h0000), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
